// File: rtl/oled_i2c_arbiter_if.sv
// Bundle of requester-side and I2C-master-side signals of the OLED I2C arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the requests and models the I2C master.
interface oled_i2c_arbiter_if;
  logic [2:0]  req;
  logic [2:0]  req_rw;
  logic [20:0] req_chip_addr;
  logic [23:0] req_reg_addr;
  logic [23:0] req_wdata;
  logic [2:0]  grant;
  logic [2:0]  ack;
  logic        err;
  logic [7:0]  rdata;
  logic        busy;
  logic [6:0]  m_chip_addr;
  logic [7:0]  m_reg_addr;
  logic [7:0]  m_wdata;
  logic        m_write_en;
  logic        m_read_en;
  logic        m_done;
  logic        m_status;
  logic [7:0]  m_rdata;

  modport slave (
    input  req, req_rw, req_chip_addr, req_reg_addr, req_wdata,
    input  m_done, m_status, m_rdata,
    output grant, ack, err, rdata, busy,
    output m_chip_addr, m_reg_addr, m_wdata, m_write_en, m_read_en
  );

  modport master (
    output req, req_rw, req_chip_addr, req_reg_addr, req_wdata,
    output m_done, m_status, m_rdata,
    input  grant, ack, err, rdata, busy,
    input  m_chip_addr, m_reg_addr, m_wdata, m_write_en, m_read_en
  );
endinterface

// File: rtl/oled_i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master between three requesters.
// One transaction at a time: IDLE -> ISSUE (start pulse) -> WAIT (done or
// timeout) -> GAP (fixed idle spacing) -> IDLE. Every output is a register or
// a decode of the state register.
module oled_i2c_arbiter #(
  parameter int unsigned GAP_CYCLES     = 16,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
  input logic                 clk,
  input logic                 reset,
  oled_i2c_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  ptr;
  logic        rw_q;
  logic [15:0] tcnt;
  logic [7:0]  gcnt;
  logic [2:0]  grant_q;
  logic [2:0]  ack_q;
  logic        err_q;
  logic [7:0]  rdata_q;
  logic [6:0]  chip_q;
  logic [7:0]  reg_q;
  logic [7:0]  wdata_q;

  logic        sel_valid;
  logic [1:0]  sel_idx;
  logic [2:0]  cand_sum;
  logic [1:0]  cand;
  logic [4:0]  chip_lsb;
  logic [4:0]  byte_lsb;
  logic        timeout_hit;
  logic        gap_last;

  assign timeout_hit = (tcnt == TIMEOUT_CYCLES - 16'd1);
  assign gap_last    = (gcnt == 8'(GAP_CYCLES - 1));
  assign chip_lsb    = {3'b000, sel_idx} * 5'd7;
  assign byte_lsb    = {sel_idx, 3'b000};

  // Pick the first pending requester at or after ptr, wrapping modulo 3.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int unsigned off = 0; off < 3; off++) begin
      cand_sum = {1'b0, ptr} + 3'(off);
      cand     = (cand_sum >= 3'd3) ? 2'(cand_sum - 3'd3) : cand_sum[1:0];
      if (!sel_valid && bus.req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode; m_done takes priority over a simultaneous timeout.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (sel_valid) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (bus.m_done || timeout_hit) state_next = GAP;
      GAP:     if (gap_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant/field latching, completion reporting and the two counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= '0;
      rw_q    <= 1'b0;
      tcnt    <= '0;
      gcnt    <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      chip_q  <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
    end else begin
      ack_q <= '0;
      err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sel_valid) begin
            grant_q <= 3'b001 << sel_idx;
            ptr     <= (sel_idx == 2'd2) ? 2'd0 : sel_idx + 2'd1;
            rw_q    <= bus.req_rw[sel_idx];
            chip_q  <= bus.req_chip_addr[chip_lsb +: 7];
            reg_q   <= bus.req_reg_addr[byte_lsb +: 8];
            wdata_q <= bus.req_wdata[byte_lsb +: 8];
          end
        end
        ISSUE: tcnt <= '0;
        WAIT: begin
          if (bus.m_done) begin
            ack_q   <= grant_q;
            err_q   <= bus.m_status;
            if (rw_q) rdata_q <= bus.m_rdata;
            grant_q <= '0;
            gcnt    <= '0;
          end else if (timeout_hit) begin
            ack_q   <= grant_q;
            err_q   <= 1'b1;
            grant_q <= '0;
            gcnt    <= '0;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        GAP: gcnt <= gcnt + 8'd1;
        default: ;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.ack         = ack_q;
  assign bus.err         = err_q;
  assign bus.rdata       = rdata_q;
  assign bus.busy        = (state != IDLE);
  assign bus.m_chip_addr = chip_q;
  assign bus.m_reg_addr  = reg_q;
  assign bus.m_wdata     = wdata_q;
  assign bus.m_write_en  = (state == ISSUE) && !rw_q;
  assign bus.m_read_en   = (state == ISSUE) && rw_q;

endmodule

// File: tb/tb_oled_i2c_arbiter.sv
// Bench for oled_i2c_arbiter: directed vector table, hand-written corner
// sequences (withdrawn request, reset mid-WAIT) and random transactions
// checked against a transaction-level reference model.
module tb_oled_i2c_arbiter;
  localparam int TO = 20;
  localparam int G  = 4;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  oled_i2c_arbiter_if bus();

  oled_i2c_arbiter #(.GAP_CYCLES(G), .TIMEOUT_CYCLES(16'd20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  rw;
    logic [20:0] chip;
    logic [23:0] regs;
    logic [23:0] wdata;
    int          n;        // WAIT cycle on which m_done is raised
    logic        status;
    logic [7:0]  mrdata;
    bit          hold;     // keep req asserted after ack
    logic [2:0]  exp_grant;
    logic        exp_err;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t tbl[10];

  // Reference model state (transaction level).
  int         ptr_m;
  logic [7:0] rdata_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v, input bit scramble);
    int own, exp_c, c_end, ack_cnt, ack_c, busy_bad, oh_bad, waited;
    logic [22:0] exp_m, ack_m;
    logic [2:0]  ack_v;
    logic        err_v;
    logic [7:0]  rd_v;
    waited = 0;
    while (bus.busy && waited < 100) begin
      tick();
      waited++;
    end
    check("idle_before_req", 32'(bus.busy), 32'd0);
    bus.req = v.req; bus.req_rw = v.rw; bus.req_chip_addr = v.chip;
    bus.req_reg_addr = v.regs; bus.req_wdata = v.wdata; bus.m_done = 1'b0;
    tick();
    check("grant", 32'(bus.grant), 32'(v.exp_grant));
    own = 0;
    for (int k = 0; k < 3; k++) if (v.exp_grant[k]) own = k;
    exp_m = {v.chip[7*own +: 7], v.regs[8*own +: 8], v.wdata[8*own +: 8]};
    check("m_fields", {bus.m_chip_addr, bus.m_reg_addr, bus.m_wdata}, exp_m);
    check("start_pulse", {bus.m_read_en, bus.m_write_en}, v.rw[own] ? 2'b10 : 2'b01);
    if (scramble) begin
      bus.req = 3'($urandom); bus.req_rw = 3'($urandom);
      bus.req_chip_addr = 21'($urandom); bus.req_wdata = 24'($urandom);
    end
    tick();
    check("start_single", {bus.m_read_en, bus.m_write_en}, 2'b00);
    exp_c = (v.n <= TO) ? v.n : TO;
    c_end = (v.n > exp_c + G) ? v.n : exp_c + G;
    ack_cnt = 0; ack_c = 0; busy_bad = 0; oh_bad = 0;
    ack_v = '0; err_v = 1'b0; rd_v = '0; ack_m = '0;
    for (int c = 1; c <= c_end; c++) begin
      bus.m_done = (c == v.n); bus.m_status = v.status; bus.m_rdata = v.mrdata;
      if (scramble && ack_cnt == 0) bus.req = 3'($urandom);
      tick();
      if (bus.ack != 3'b000) begin
        ack_cnt++; ack_c = c; ack_v = bus.ack; err_v = bus.err; rd_v = bus.rdata;
        ack_m = {bus.m_chip_addr, bus.m_reg_addr, bus.m_wdata};
        if (!v.hold) bus.req = 3'b000;
      end
      if ((bus.grant & (bus.grant - 3'd1)) != 3'b000) oh_bad++;
      if (bus.busy != (c < exp_c + G)) busy_bad++;
    end
    bus.m_done = 1'b0;
    check("ack_count", ack_cnt, 1);
    check("ack_latency", ack_c, exp_c);
    check("ack_owner", 32'(ack_v), 32'(v.exp_grant));
    check("err", 32'(err_v), 32'(v.exp_err));
    check("rdata", 32'(rd_v), 32'(v.exp_rdata));
    check("m_fields_stable", ack_m, exp_m);
    check("grant_onehot", oh_bad, 0);
    check("busy_gap_len", busy_bad, 0);
  endtask

  initial begin
    vec_t r;
    int   own, bad;
    n_pass = 0; n_total = 0;
    bus.req = '0; bus.req_rw = '0; bus.req_chip_addr = '0; bus.req_reg_addr = '0;
    bus.req_wdata = '0; bus.m_done = 1'b0; bus.m_status = 1'b0; bus.m_rdata = '0;

    //          req     rw      chip                      regs                  wdata                 n   st    mrdata hold grant   err   rdata
    tbl[0] = '{3'b111, 3'b000, {7'h12, 7'h34, 7'h56}, 24'h102030,           24'hA1B2C3,           2,  1'b0, 8'h11, 1, 3'b001, 1'b0, 8'h00};
    tbl[1] = '{3'b111, 3'b000, {7'h12, 7'h34, 7'h56}, 24'h102030,           24'hA1B2C3,           3,  1'b0, 8'h22, 1, 3'b010, 1'b0, 8'h00};
    tbl[2] = '{3'b111, 3'b000, {7'h12, 7'h34, 7'h56}, 24'h102030,           24'hA1B2C3,           1,  1'b0, 8'h33, 1, 3'b100, 1'b0, 8'h00};
    tbl[3] = '{3'b111, 3'b000, {7'h12, 7'h34, 7'h56}, 24'h102030,           24'hA1B2C3,           4,  1'b0, 8'h44, 0, 3'b001, 1'b0, 8'h00};
    tbl[4] = '{3'b001, 3'b000, {7'h11, 7'h22, 7'h3C}, {8'h55, 8'h66, 8'h00}, {8'h77, 8'h88, 8'hAE}, 3,  1'b0, 8'h99, 0, 3'b001, 1'b0, 8'h00};
    tbl[5] = '{3'b100, 3'b100, {7'h45, 7'h22, 7'h3C}, 24'h800102,           24'h030405,           5,  1'b0, 8'h5A, 0, 3'b100, 1'b0, 8'h5A};
    tbl[6] = '{3'b010, 3'b000, {7'h01, 7'h02, 7'h03}, 24'h0A0B0C,           24'h0D0E0F,           1,  1'b1, 8'hEE, 0, 3'b010, 1'b1, 8'h5A};
    tbl[7] = '{3'b011, 3'b001, {7'h71, 7'h62, 7'h53}, 24'h445566,           24'h778899,           24, 1'b0, 8'hBB, 0, 3'b001, 1'b1, 8'h5A};
    tbl[8] = '{3'b110, 3'b010, {7'h0F, 7'h1E, 7'h2D}, 24'hCAFE01,           24'hBEEF02,           20, 1'b0, 8'hC3, 0, 3'b010, 1'b0, 8'hC3};
    tbl[9] = '{3'b101, 3'b000, {7'h2A, 7'h15, 7'h6B}, 24'h135724,           24'h681357,           19, 1'b0, 8'h66, 0, 3'b100, 1'b0, 8'hC3};

    reset = 1'b1;
    repeat (2) tick();
    check("reset_ctl", {bus.grant, bus.ack, bus.err, bus.busy, bus.m_write_en, bus.m_read_en}, 32'd0);
    check("reset_data", {bus.rdata, bus.m_chip_addr, bus.m_reg_addr, bus.m_wdata}, 32'd0);
    #3 reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_txn(tbl[i], 1'b0);

    // Request raised only during GAP and dropped before GAP ends is withdrawn.
    bus.req = 3'b001; bus.req_rw = 3'b000;
    tick();
    check("wd_grant", 32'(bus.grant), 32'b001);
    bus.req = 3'b000;
    tick();
    bus.m_done = 1'b1; bus.m_status = 1'b0;
    tick();
    check("wd_ack", 32'(bus.ack), 32'b001);
    bus.m_done = 1'b0;
    bus.req = 3'b010;
    repeat (2) tick();
    bus.req = 3'b000;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.grant != 3'b000 || bus.ack != 3'b000) bad++;
    end
    check("wd_no_grant", bad, 0);
    check("wd_idle", 32'(bus.busy), 32'd0);

    // Reset in the middle of WAIT: no ack, all outputs cleared, ptr back to 0.
    bus.req = 3'b100; bus.req_chip_addr = 21'h1FFFFF; bus.req_reg_addr = 24'hFFFFFF;
    bus.req_wdata = 24'hFFFFFF;
    tick();
    check("rst_grant", 32'(bus.grant), 32'b100);
    bus.req = 3'b000;
    repeat (2) tick();
    #2 reset = 1'b1;
    #1;
    check("rst_ctl", {bus.grant, bus.ack, bus.err, bus.busy, bus.m_write_en, bus.m_read_en}, 32'd0);
    check("rst_data", {bus.rdata, bus.m_chip_addr, bus.m_reg_addr, bus.m_wdata}, 32'd0);
    bus.m_done = 1'b1;
    repeat (2) tick();
    check("rst_no_ack", 32'(bus.ack), 32'd0);
    #3 reset = 1'b0; bus.m_done = 1'b0;
    tick();
    bus.req = 3'b110; bus.req_rw = 3'b000;
    tick();
    check("rst_ptr0", 32'(bus.grant), 32'b010);
    bus.req = 3'b000;
    tick();
    bus.m_done = 1'b1;
    tick();
    check("rst_ack", 32'(bus.ack), 32'b010);
    bus.m_done = 1'b0;
    repeat (G + 2) tick();

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    ptr_m = 0; rdata_m = 8'h00;

    for (int t = 0; t < 40; t++) begin
      r.req    = 3'($urandom_range(1, 7));
      r.rw     = 3'($urandom);
      r.chip   = 21'($urandom);
      r.regs   = 24'($urandom);
      r.wdata  = 24'($urandom);
      r.n      = $urandom_range(1, TO + G);
      r.status = 1'($urandom);
      r.mrdata = 8'($urandom);
      r.hold   = 0;
      own = -1;
      for (int k = 0; k < 3; k++)
        if (own < 0 && r.req[(ptr_m + k) % 3]) own = (ptr_m + k) % 3;
      ptr_m = (own + 1) % 3;
      r.exp_grant = 3'(1 << own);
      r.exp_err   = (r.n <= TO) ? r.status : 1'b1;
      if (r.n <= TO && r.rw[own]) rdata_m = r.mrdata;
      r.exp_rdata = rdata_m;
      run_txn(r, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/oled_i2c_arbiter.md
OLED_I2C_ARBITER -- requirements
Module: oled_i2c_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- GAP_CYCLES, 16, idle cycles between successive transactions; legal range 1..255.
- TIMEOUT_CYCLES, 16'hFFFF, maximum WAIT cycles before abort.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  3  transaction request, one bit per requester.
- req_rw  in  3  per requester: 1 = read, 0 = write.
- req_chip_addr  in  21  requester i at [7i+6:7i].
- req_reg_addr  in  24  requester i at [8i+7:8i].
- req_wdata  in  24  requester i at [8i+7:8i].
- grant  out  3  one-hot, identifies the owner of the master.
- ack  out  3  one-cycle completion pulse to the owner.
- err  out  1  valid with ack; 1 = NACK or timeout.
- rdata  out  8  read data, valid with ack on reads.
- busy  out  1  high in any state other than IDLE.
- m_chip_addr  out  7  chip address to the I2C master.
- m_reg_addr  out  8  register address to the I2C master.
- m_wdata  out  8  write data to the I2C master.
- m_write_en  out  1  write start pulse.
- m_read_en  out  1  read start pulse.
- m_done  in  1  master completion pulse.
- m_status  in  1  master NACK flag, valid with m_done.
- m_rdata  in  8  master read data, valid with m_done.

Function
REQ-003 FSM states: IDLE, ISSUE, WAIT, GAP. All outputs are registered or decoded from state only. No combinational path from inputs to outputs.
REQ-004 IDLE with req != 0 at a clock edge:
- Select the first set req bit at or after ptr, searching upward modulo 3.
- At that edge, load m_chip_addr, m_reg_addr, m_wdata and the rw latch from the selected requester.
- Set the grant bit for that requester and go to ISSUE.
REQ-005 ptr update: on each grant, ptr <= (granted index + 1) mod 3.
REQ-006 ISSUE lasts exactly one cycle.
- m_write_en = 1 if the latched rw = 0; m_read_en = 1 if the latched rw = 1.
- Never both. Next state is WAIT.
REQ-007 WAIT:
- Clear the timeout counter on WAIT entry.
- m_done is sampled only in WAIT; m_done in any other state is ignored.
REQ-008 WAIT with m_done = 1:
- Next cycle: ack[owner] = 1 for exactly one cycle and err = m_status.
- On a read, rdata = m_rdata; on a write, rdata holds its previous value.
- Go to GAP.
REQ-009 Timeout: if the counter reaches TIMEOUT_CYCLES in WAIT without m_done, pulse ack[owner] with err = 1, leave rdata unchanged, go to GAP. A later stray m_done is ignored.
REQ-010 GAP:
- grant clears to 0 on GAP entry.
- Hold for exactly GAP_CYCLES cycles, then go to IDLE.
- req is ignored during GAP.
REQ-011 Request rules:
- Dropping req before grant withdraws the request; no ack is produced.
- req changes after grant are ignored until GAP ends.
- m_* fields stay stable from grant until the next grant.
REQ-012 A req held high after ack is a new request, arbitrated in IDLE under the updated ptr.
REQ-013 m_done and the timeout on the same cycle: m_done wins, err = m_status.
REQ-014 Latency:
- req sampled in IDLE at edge k -> grant at k.
- m_*_en high during cycle k+1.
- ack the cycle after the m_done edge.
- Minimum request-to-request spacing is 3 + GAP_CYCLES cycles.

Reset
REQ-015 Asserting reset immediately forces state = IDLE and ptr = 0.
- grant, ack, err, busy, m_write_en, m_read_en = 0.
- rdata, m_chip_addr, m_reg_addr, m_wdata = 0.
- Timeout and gap counters = 0.
REQ-016 Reset during ISSUE, WAIT or GAP aborts the transaction with no ack. After reset releases, the first request is arbitrated from ptr = 0.

Verification
REQ-017 Required directed scenarios:
- Single write: req = 3'b001, chip 7'h3C, reg 8'h00, data 8'hAE -> grant = 001; one m_write_en pulse with m_chip_addr = 3C, m_reg_addr = 00, m_wdata = AE; m_done = 1 with m_status = 0 -> ack = 001, err = 0; after GAP_CYCLES, busy = 0.
- Fairness: req = 3'b111 held through three transactions -> grants in order 001, 010, 100, then 001 again; each ack only to its owner; no cycle with two grant bits set.
- Read: req[2] with rw = 1; m_done with m_rdata = 8'h5A -> ack = 100, rdata = 5A, m_read_en pulsed once, m_write_en never.
- NACK and timeout: m_status = 1 at done -> err = 1. With TIMEOUT_CYCLES = 20 and m_done never asserted -> ack with err = 1 exactly 20 cycles after WAIT entry; a later m_done is ignored.
- Reset mid-WAIT: assert reset -> all outputs 0 with no ack. After release, req = 3'b110 -> grant = 010 (ptr = 0).
